bicubic_line_reader: RTL
========================

Name: bicubic_line_reader

Overview:
- Read-side controller for the 5-line bicubic line buffer; the consumer end of that buffer's rd_ready / rd_en / rd_addr / rd_finish handshake.
- For each destination pixel, computes the source coordinate in unsigned fixed point and issues a buffer read at the integer source column.
- Retires source lines with rd_finish as the destination row advances.
- Emits the fractional phases and destination coordinates, aligned to the buffer's 4x4 pixel window, for the bicubic interpolation core downstream.

Parameters:
- ADDR_W, 11: width of column address, widths and heights.
- FRAC_W, 16: fractional bits of scale factors and accumulators.
- PHASE_W, 8: fractional bits forwarded to the interpolator.
- RD_LAT, 2: cycles from rd_en to the line buffer's valid_o.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- src_width  in  ADDR_W  source columns; must be >=1.
- dst_width  in  ADDR_W  destination columns; must be >=1.
- dst_height  in  ADDR_W  destination rows; must be >=1.
- scale_x  in  ADDR_W+FRAC_W  src_width/dst_width, unsigned Q11.16.
- scale_y  in  ADDR_W+FRAC_W  src_height/dst_height, unsigned Q11.16.
- rd_ready  in  1  line buffer holds 3 complete lines.
- out_ready  in  1  interpolator can accept new reads.
- rd_en  out  1  read strobe to line buffer.
- rd_addr  out  ADDR_W  source column address.
- rd_finish  out  1  one-cycle pulse; retire oldest line.
- coord_valid  out  1  high in the same cycle as the buffer's valid_o.
- frac_x  out  PHASE_W  horizontal phase.
- frac_y  out  PHASE_W  vertical phase.
- dst_x  out  ADDR_W  destination column.
- dst_y  out  ADDR_W  destination row.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last read of the frame.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All outputs go to 0, the FSM goes to IDLE, accumulators clear and the alignment pipe clears.
  - Reset mid-row abandons the frame. No rd_finish is issued.
- Configuration inputs are sampled on start and held internally for the frame. start is ignored unless the FSM is in IDLE.
- Accumulators:
  - sx_acc, sy_acc are ADDR_W+FRAC_W bits wide.
  - x0 = sx_acc[top ADDR_W bits], clamped to src_width-1.
  - frac = top PHASE_W bits of the fractional field.
  - sx_acc resets to its initial value at each row start and adds scale_x per issued read.
  - sy_acc adds scale_y per completed row.
- FSM states and transitions:
  - IDLE: start -> WAIT_RDY; busy goes high on the next cycle.
  - WAIT_RDY: rd_ready=1 -> READ_ROW.
  - READ_ROW:
    - Each cycle with out_ready=1 asserts rd_en with rd_addr=x0, then increments dst_x and sx_acc.
    - When out_ready=0, no rd_en is asserted and all state holds.
    - After read dst_width-1 -> ADVANCE.
  - ADVANCE:
    - drop = y0(next row) - y0(current row).
    - Issue drop rd_finish pulses. Each pulse requires rd_ready=1, and pulses are separated by at least one idle cycle, because rd_ready settles one cycle after rd_finish.
    - drop=0 -> no pulse.
    - When all drops are issued: last row -> DONE, else -> WAIT_RDY.
  - DONE: pulse frame_done once the last coord_valid has left; busy=0; -> IDLE.
- No flush: lines remaining in the buffer at frame end are cleared by the frame-level reset of the buffer.
- Alignment: frac_x, frac_y, dst_x and dst_y travel through an RD_LAT-deep pipe alongside rd_en, so coord_valid and these outputs appear exactly RD_LAT cycles after the matching rd_en.
- Backpressure: out_ready gates only new reads. Up to RD_LAT reads already in flight always complete; the interpolator provides a skid of depth RD_LAT.
- Clamp: a column beyond src_width-1 saturates to src_width-1 and frac_x still reports the phase. Row index never exceeds the lines held.

Optional Feature:
- Macro: HALF_PIXEL_CENTER_EN.
- Defined:
  - Initial accumulator = (scale-1.0)/2, giving src = (dst+0.5)*scale-0.5.
  - A negative result clamps to column/row 0 with frac=0.
  - drop is computed from the clamped y0.
- Undefined: initial accumulator = 0, giving src = dst*scale (corner-aligned).

Test Plan:
- Identity: src 4x4, dst 4x4, scale 0x10000 -> rd_addr 0,1,2,3 per row; frac_x=frac_y=0; one rd_finish after each of rows 0-2; none after row 3; frame_done after 16 coord_valid.
- 2x upscale: 4x4 to 8x8, scale 0x08000 -> rd_addr 0,0,1,1,2,2,3,3; frac_x 0,128 alternating; rd_finish only after dst rows 1,3,5; none after even rows.
- 2x downscale: 8x8 to 4x4, scale 0x20000 -> rd_addr 0,2,4,6; two rd_finish pulses per row boundary at least 2 cycles apart, each only while rd_ready=1.
- Stalls:
  - Hold rd_ready=0 for 10 cycles in WAIT_RDY -> no rd_en and no rd_finish.
  - Toggle out_ready every cycle -> rd_en only when out_ready=1; coord_valid exactly 2 cycles after each rd_en; dst_x is contiguous.
- Reset mid-row: reset_n=0 at dst_x=3 of row 1 -> next cycle all outputs 0 and busy=0; new start restarts at dst_x=0, dst_y=0.
- HALF_PIXEL_CENTER_EN defined, 2x upscale -> dst_x 0 gives rd_addr 0, frac 0 (clamped); dst_x 1 gives rd_addr 0, frac 64; dst_x 2 gives rd_addr 0, frac 192.

Source files
------------

// File: rtl/bicubic_line_reader.sv
// bicubic_line_reader
//   Read-side controller for the 5-line bicubic line buffer. For every
//   destination pixel it steps an unsigned fixed-point source coordinate,
//   issues a buffer read at the integer source column, retires source lines
//   with rd_finish as the destination row advances, and forwards the phases
//   and destination coordinates aligned to the buffer's read latency.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   start                   one-cycle frame start (accepted only when idle)
//   src_width, dst_width,   frame geometry, captured on start
//   dst_height
//   scale_x, scale_y        src/dst ratios, unsigned Q11.16, captured on start
//   rd_ready                line buffer holds enough lines for a row
//   out_ready               interpolator can accept new reads
//   rd_en, rd_addr          read strobe and source column
//   rd_finish               retire the oldest buffered line
//   coord_valid             aligned with the buffer's valid_o
//   frac_x, frac_y          interpolation phases
//   dst_x, dst_y            destination coordinate of the read
//   busy, frame_done        frame status
//
// Build option
//   HALF_PIXEL_CENTER_EN    when defined, src = (dst+0.5)*scale-0.5 with
//                           negative coordinates clamped to 0 (phase 0);
//                           otherwise src = dst*scale (corner aligned).

module bicubic_line_reader #(
    parameter int ADDR_W  = 11,
    parameter int FRAC_W  = 16,
    parameter int PHASE_W = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        src_width,
    input  logic [ADDR_W-1:0]        dst_width,
    input  logic [ADDR_W-1:0]        dst_height,
    input  logic [ADDR_W+FRAC_W-1:0] scale_x,
    input  logic [ADDR_W+FRAC_W-1:0] scale_y,
    input  logic                     rd_ready,
    input  logic                     out_ready,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_finish,
    output logic                     coord_valid,
    output logic [PHASE_W-1:0]       frac_x,
    output logic [PHASE_W-1:0]       frac_y,
    output logic [ADDR_W-1:0]        dst_x,
    output logic [ADDR_W-1:0]        dst_y,
    output logic                     busy,
    output logic                     frame_done
);

`ifdef HALF_PIXEL_CENTER_EN
    localparam bit HALF_PIXEL = 1'b1;
`else
    localparam bit HALF_PIXEL = 1'b0;
`endif

    // One extra sign bit so the half-pixel start offset can go negative.
    localparam int ACC_W = ADDR_W + FRAC_W + 1;
    localparam logic signed [ACC_W-1:0] ONE =
        {{(ACC_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, WAIT_RDY, READ_ROW, ADVANCE, DONE} state_t;

    function automatic logic signed [ACC_W-1:0] init_acc(input logic [ACC_W-2:0] scale);
        logic signed [ACC_W-1:0] s;
        s = $signed({1'b0, scale});
        return HALF_PIXEL ? ((s - ONE) >>> 1) : '0;
    endfunction

    function automatic logic [ADDR_W-1:0] sat_col(input logic neg,
                                                  input logic [ADDR_W-1:0] ipart,
                                                  input logic [ADDR_W-1:0] width);
        logic [ADDR_W-1:0] lim;
        lim = width - 1'b1;
        if (neg)              return '0;
        else if (ipart > lim) return lim;
        else                  return ipart;
    endfunction

    function automatic logic [ADDR_W-1:0] sat_row(input logic neg,
                                                  input logic [ADDR_W-1:0] ipart);
        return neg ? '0 : ipart;
    endfunction

    function automatic logic [PHASE_W-1:0] sat_phase(input logic neg,
                                                     input logic [PHASE_W-1:0] f);
        return neg ? '0 : f;
    endfunction

    state_t                  state;
    logic [ADDR_W-1:0]       src_w, dst_w, dst_h;
    logic [ADDR_W+FRAC_W-1:0] scl_x, scl_y;
    logic signed [ACC_W-1:0] sx_acc, sy_acc;
    logic [ADDR_W-1:0]       cur_x, cur_y, drop_cnt;
    logic                    gap;

    // Alignment pipe: index 0 is coincident with rd_en, index RD_LAT with valid_o.
    logic                    vld_p [0:RD_LAT];
    logic [PHASE_W-1:0]      fx_p  [0:RD_LAT];
    logic [PHASE_W-1:0]      fy_p  [0:RD_LAT];
    logic [ADDR_W-1:0]       dx_p  [0:RD_LAT];
    logic [ADDR_W-1:0]       dy_p  [0:RD_LAT];

    logic signed [ACC_W-1:0] sx_step, sy_next;
    logic [ADDR_W-1:0]       x0, y0_cur, y0_next;
    logic [PHASE_W-1:0]      ph_x, ph_y;
    logic                    pipe_busy;
    logic                    last_col, last_row;

    assign sx_step  = sx_acc + $signed({1'b0, scl_x});
    assign sy_next  = sy_acc + $signed({1'b0, scl_y});
    assign x0       = sat_col(sx_acc[ACC_W-1], sx_acc[ACC_W-2:FRAC_W], src_w);
    assign y0_cur   = sat_row(sy_acc[ACC_W-1], sy_acc[ACC_W-2:FRAC_W]);
    assign y0_next  = sat_row(sy_next[ACC_W-1], sy_next[ACC_W-2:FRAC_W]);
    assign ph_x     = sat_phase(sx_acc[ACC_W-1], sx_acc[FRAC_W-1 -: PHASE_W]);
    assign ph_y     = sat_phase(sy_acc[ACC_W-1], sy_acc[FRAC_W-1 -: PHASE_W]);
    assign last_col = (cur_x == dst_w - 1'b1);
    assign last_row = (cur_y == dst_h - 1'b1);

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) pipe_busy = pipe_busy | vld_p[k];
    end

    assign rd_en       = vld_p[0];
    assign coord_valid = vld_p[RD_LAT];
    assign frac_x      = fx_p[RD_LAT];
    assign frac_y      = fy_p[RD_LAT];
    assign dst_x       = dx_p[RD_LAT];
    assign dst_y       = dy_p[RD_LAT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_w      <= '0;
            dst_w      <= '0;
            dst_h      <= '0;
            scl_x      <= '0;
            scl_y      <= '0;
            sx_acc     <= '0;
            sy_acc     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            drop_cnt   <= '0;
            gap        <= 1'b0;
            rd_addr    <= '0;
            rd_finish  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k <= RD_LAT; k++) begin
                vld_p[k] <= 1'b0;
                fx_p[k]  <= '0;
                fy_p[k]  <= '0;
                dx_p[k]  <= '0;
                dy_p[k]  <= '0;
            end
        end else begin
            rd_finish  <= 1'b0;
            frame_done <= 1'b0;

            // Stage boundary: reads in flight always advance toward valid_o.
            vld_p[0] <= 1'b0;
            for (int k = 1; k <= RD_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                fx_p[k]  <= fx_p[k-1];
                fy_p[k]  <= fy_p[k-1];
                dx_p[k]  <= dx_p[k-1];
                dy_p[k]  <= dy_p[k-1];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        src_w  <= src_width;
                        dst_w  <= dst_width;
                        dst_h  <= dst_height;
                        scl_x  <= scale_x;
                        scl_y  <= scale_y;
                        sx_acc <= init_acc(scale_x);
                        sy_acc <= init_acc(scale_y);
                        cur_x  <= '0;
                        cur_y  <= '0;
                        busy   <= 1'b1;
                        state  <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (rd_ready) state <= READ_ROW;
                end
                READ_ROW: begin
                    if (out_ready) begin
                        // Stage boundary: launch a read into the alignment pipe.
                        vld_p[0] <= 1'b1;
                        rd_addr  <= x0;
                        fx_p[0]  <= ph_x;
                        fy_p[0]  <= ph_y;
                        dx_p[0]  <= cur_x;
                        dy_p[0]  <= cur_y;
                        if (last_col) begin
                            // No lines are retired after the final row.
                            drop_cnt <= last_row ? '0 : (y0_next - y0_cur);
                            gap      <= 1'b0;
                            state    <= ADVANCE;
                        end else begin
                            cur_x  <= cur_x + 1'b1;
                            sx_acc <= sx_step;
                        end
                    end
                end
                ADVANCE: begin
                    if (drop_cnt == '0) begin
                        if (last_row) begin
                            state <= DONE;
                        end else begin
                            cur_y  <= cur_y + 1'b1;
                            cur_x  <= '0;
                            sx_acc <= init_acc(scl_x);
                            sy_acc <= sy_next;
                            state  <= WAIT_RDY;
                        end
                    end else if (gap) begin
                        // rd_ready is stale for one cycle after a retire.
                        gap <= 1'b0;
                    end else if (rd_ready) begin
                        rd_finish <= 1'b1;
                        drop_cnt  <= drop_cnt - 1'b1;
                        gap       <= 1'b1;
                    end
                end
                DONE: begin
                    if (!pipe_busy) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
